// File: rtl/fp_mul_exp_pipe.sv
// fp_mul_exp_pipe
//   Exponent path of the floating-point multiplier. Unpacks two IEEE-754-style
//   operands, classifies each one (zero / subnormal / normal / inf / NaN) and
//   produces the biased product exponent, the result sign, overflow/underflow
//   flags and the special-result class. Two register stages with valid/ready
//   flow control sit between the operands and the normaliser/rounder.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : synchronous reset, active low
//   in_valid   : operand pair valid
//   in_ready   : block can accept an operand pair this cycle (combinational)
//   mul1, mul2 : operands {sign, exp, mant}
//   out_valid  : result valid
//   out_ready  : downstream accepts the result
//   res_sign   : XOR of the operand signs (also for NaN results)
//   res_exp    : biased exponent, saturated to all-ones / zero or forced by specials
//   exp_raw    : signed, unsaturated biased exponent sum (EXP_WIDTH+2 bits)
//   ovf, unf   : exponent overflow / underflow, finite non-zero operands only
//   is_zero, is_inf, is_nan : special-result class, one-hot or all zero
module fp_mul_exp_pipe #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [EXP_WIDTH+MANT_WIDTH:0]   mul1,
  input  logic [EXP_WIDTH+MANT_WIDTH:0]   mul2,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            res_sign,
  output logic [EXP_WIDTH-1:0]            res_exp,
  output logic [EXP_WIDTH+1:0]            exp_raw,
  output logic                            ovf,
  output logic                            unf,
  output logic                            is_zero,
  output logic                            is_inf,
  output logic                            is_nan
);

  localparam int FP_WIDTH = 1 + EXP_WIDTH + MANT_WIDTH;
  // Two extra bits: one for the carry of the add, one for the sign.
  localparam int SW = EXP_WIDTH + 2;
  localparam logic [SW-1:0] BIAS_C = SW'((2 ** (EXP_WIDTH - 1)) - 1);
  localparam logic [SW-1:0] EMAX_C = SW'((2 ** EXP_WIDTH) - 1);

  // Subnormals share the exponent of the smallest normal (emin = 1).
  function automatic logic [SW-1:0] eff_exp(input logic [EXP_WIDTH-1:0] e);
    if (e == {EXP_WIDTH{1'b0}}) begin
      eff_exp = {{(SW-1){1'b0}}, 1'b1};
    end else begin
      eff_exp = {2'b00, e};
    end
  endfunction

  // Class bits returned as {zero, inf, nan}.
  function automatic logic [2:0] classify(input logic [EXP_WIDTH-1:0] e,
                                          input logic [MANT_WIDTH-1:0] m);
    logic exp_zero;
    logic exp_ones;
    logic mant_zero;
    exp_zero  = (e == {EXP_WIDTH{1'b0}});
    exp_ones  = &e;
    mant_zero = (m == {MANT_WIDTH{1'b0}});
    classify  = {exp_zero & mant_zero, exp_ones & mant_zero, exp_ones & ~mant_zero};
  endfunction

  // Flow-control and stage registers
  logic          s1_valid_r;
  logic          s1_sign_r;
  logic [SW-1:0] s1_sum_r;
  logic [2:0]    s1_cls_a_r;
  logic [2:0]    s1_cls_b_r;
  logic          s2_valid_r;
  logic          s2_sign_r;
  logic [EXP_WIDTH-1:0] s2_exp_r;
  logic [SW-1:0] s2_raw_r;
  logic          s2_ovf_r;
  logic          s2_unf_r;
  logic          s2_zero_r;
  logic          s2_inf_r;
  logic          s2_nan_r;

  logic          s1_en_s;
  logic          s2_en_s;

  // Stage 1 combinational results
  logic [EXP_WIDTH-1:0]  a_exp_s;
  logic [EXP_WIDTH-1:0]  b_exp_s;
  logic [MANT_WIDTH-1:0] a_mant_s;
  logic [MANT_WIDTH-1:0] b_mant_s;
  logic [SW-1:0]         sum_s;

  // Stage 2 combinational results
  logic                 nan_s;
  logic                 inf_s;
  logic                 zero_s;
  logic                 ovf_s;
  logic                 unf_s;
  logic [EXP_WIDTH-1:0] exp_s;

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    s2_en_s  = ~s2_valid_r | out_ready;
    s1_en_s  = ~s1_valid_r | s2_en_s;
    in_ready = s1_en_s;
  end

  // Stage 1: unpack operands and form the biased exponent sum.
  always_comb begin
    a_exp_s  = mul1[FP_WIDTH-2 -: EXP_WIDTH];
    b_exp_s  = mul2[FP_WIDTH-2 -: EXP_WIDTH];
    a_mant_s = mul1[MANT_WIDTH-1:0];
    b_mant_s = mul2[MANT_WIDTH-1:0];
    // Range is [2-BIAS, 2*EMAX-BIAS], which always fits SW bits signed.
    sum_s    = eff_exp(a_exp_s) + eff_exp(b_exp_s) - BIAS_C;
  end

  // Stage 2: special-value resolution and exponent saturation.
  always_comb begin
    // 0 * inf is invalid and yields NaN, regardless of operand order.
    nan_s  = s1_cls_a_r[0] | s1_cls_b_r[0] |
             (s1_cls_a_r[1] & s1_cls_b_r[2]) | (s1_cls_a_r[2] & s1_cls_b_r[1]);
    inf_s  = ~nan_s & (s1_cls_a_r[1] | s1_cls_b_r[1]);
    zero_s = ~nan_s & ~inf_s & (s1_cls_a_r[2] | s1_cls_b_r[2]);
    ovf_s  = ~(nan_s | inf_s | zero_s) & ($signed(s1_sum_r) >= $signed(EMAX_C));
    unf_s  = ~(nan_s | inf_s | zero_s) & ($signed(s1_sum_r) <= $signed({SW{1'b0}}));
    if (nan_s | inf_s | ovf_s) begin
      exp_s = {EXP_WIDTH{1'b1}};
    end else if (zero_s | unf_s) begin
      exp_s = {EXP_WIDTH{1'b0}};
    end else begin
      exp_s = s1_sum_r[EXP_WIDTH-1:0];
    end
  end

  // Stage 1 register: captures the sum, sign and operand classes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_sum_r   <= {SW{1'b0}};
      s1_cls_a_r <= 3'b000;
      s1_cls_b_r <= 3'b000;
    end else if (s1_en_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_sign_r  <= mul1[FP_WIDTH-1] ^ mul2[FP_WIDTH-1];
        s1_sum_r   <= sum_s;
        s1_cls_a_r <= classify(a_exp_s, a_mant_s);
        s1_cls_b_r <= classify(b_exp_s, b_mant_s);
      end
    end
  end

  // Stage 2 register: drives the block outputs directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_sign_r  <= 1'b0;
      s2_exp_r   <= {EXP_WIDTH{1'b0}};
      s2_raw_r   <= {SW{1'b0}};
      s2_ovf_r   <= 1'b0;
      s2_unf_r   <= 1'b0;
      s2_zero_r  <= 1'b0;
      s2_inf_r   <= 1'b0;
      s2_nan_r   <= 1'b0;
    end else if (s2_en_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_sign_r <= s1_sign_r;
        s2_exp_r  <= exp_s;
        s2_raw_r  <= s1_sum_r;
        s2_ovf_r  <= ovf_s;
        s2_unf_r  <= unf_s;
        s2_zero_r <= zero_s;
        s2_inf_r  <= inf_s;
        s2_nan_r  <= nan_s;
      end
    end
  end

  // Output port mapping
  always_comb begin
    out_valid = s2_valid_r;
    res_sign  = s2_sign_r;
    res_exp   = s2_exp_r;
    exp_raw   = s2_raw_r;
    ovf       = s2_ovf_r;
    unf       = s2_unf_r;
    is_zero   = s2_zero_r;
    is_inf    = s2_inf_r;
    is_nan    = s2_nan_r;
  end

endmodule

// File: tb/tb_fp_mul_exp_pipe.sv
// Self-checking bench for fp_mul_exp_pipe (EXP_WIDTH=8, MANT_WIDTH=23).
// A table of operand pairs with hand-derived expected results feeds a
// scoreboard queue; a negedge monitor pushes on input transfers and
// pops/compares on output transfers. Hand-written sequences cover latency,
// backpressure, stall stability and reset with data in flight.
module tb_fp_mul_exp_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] mul1;
  logic [31:0] mul2;
  logic        out_valid;
  logic        out_ready;
  logic        res_sign;
  logic [7:0]  res_exp;
  logic [9:0]  exp_raw;
  logic        ovf;
  logic        unf;
  logic        is_zero;
  logic        is_inf;
  logic        is_nan;

  fp_mul_exp_pipe #(.EXP_WIDTH(8), .MANT_WIDTH(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mul1(mul1), .mul2(mul2), .out_valid(out_valid), .out_ready(out_ready),
    .res_sign(res_sign), .res_exp(res_exp), .exp_raw(exp_raw),
    .ovf(ovf), .unf(unf), .is_zero(is_zero), .is_inf(is_inf), .is_nan(is_nan)
  );

  always #5 clk = ~clk;

  // Expected record packing: {sign, res_exp[7:0], exp_raw[9:0], ovf, unf, zero, inf, nan}
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [23:0] exp_out;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];
  logic [31:0] q_a[$];
  logic [23:0] sb_q[$];

  int checks = 0;
  int failures = 0;
  int out_count = 0;
  logic        hold_prev = 1'b0;
  logic [23:0] hold_val;

  function automatic logic [23:0] actual_out();
    return {res_sign, res_exp, exp_raw, ovf, unf, is_zero, is_inf, is_nan};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp_v);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [7:0] e, input int raw,
                         input logic [4:0] flags);
    logic [9:0] raw10;
    raw10 = 10'(raw);
    vecs[i].a = a;
    vecs[i].b = b;
    vecs[i].exp_out = {s, e, raw10, flags};
  endtask

  // Scoreboard monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_prev) begin
        chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
        chk("stall_data_held", {8'd0, actual_out()}, {8'd0, hold_val});
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(vecs_lookup(mul1, mul2));
      end
      if (out_valid && out_ready) begin
        out_count++;
        if (sb_q.size() == 0) begin
          chk("unexpected_output", {31'd0, out_valid}, 32'd0);
        end else begin
          chk("result", {8'd0, actual_out()}, {8'd0, sb_q.pop_front()});
        end
      end
      hold_prev = out_valid && !out_ready;
      hold_val  = actual_out();
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Expected record for the operand pair currently driven (pairs are unique).
  function automatic logic [23:0] vecs_lookup(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].a == a && vecs[i].b == b) return vecs[i].exp_out;
    end
    return 24'hFFFFFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i);
    mul1 = vecs[i].a;
    mul2 = vecs[i].b;
    in_valid = 1'b1;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    while (sb_q.size() != 0 && budget < 40) begin
      tick();
      budget++;
    end
    chk(name, sb_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int accepts;
    int stalls;
    logic acc;

    //        a             b             s     exp    raw   {ovf,unf,z,i,n}
    set_vec(0,  32'h40000000, 32'h40400000, 1'b0, 8'h81, 129,  5'b00000);
    set_vec(1,  32'h7F000000, 32'hFF000000, 1'b1, 8'hFF, 381,  5'b10000);
    set_vec(2,  32'h00800000, 32'h00000001, 1'b0, 8'h00, -125, 5'b01000);
    set_vec(3,  32'h00000000, 32'h7F800000, 1'b0, 8'hFF, 129,  5'b00001);
    set_vec(4,  32'h7F800000, 32'h3F800000, 1'b0, 8'hFF, 255,  5'b00010);
    set_vec(5,  32'h3F800000, 32'hBF800000, 1'b1, 8'h7F, 127,  5'b00000);
    set_vec(6,  32'h7F000000, 32'h3F800000, 1'b0, 8'hFE, 254,  5'b00000);
    set_vec(7,  32'h7F000000, 32'h40000000, 1'b0, 8'hFF, 255,  5'b10000);
    set_vec(8,  32'h00800000, 32'h3F800000, 1'b0, 8'h01, 1,    5'b00000);
    set_vec(9,  32'h00800000, 32'h3F000000, 1'b0, 8'h00, 0,    5'b01000);
    set_vec(10, 32'h80000000, 32'h40000000, 1'b1, 8'h00, 2,    5'b00100);
    set_vec(11, 32'h7FC00000, 32'h3F800000, 1'b0, 8'hFF, 255,  5'b00001);
    set_vec(12, 32'hFFC00000, 32'h3F800000, 1'b1, 8'hFF, 255,  5'b00001);
    set_vec(13, 32'h7F800000, 32'hFF800000, 1'b1, 8'hFF, 383,  5'b00010);
    set_vec(14, 32'h00000000, 32'h00000000, 1'b0, 8'h00, -125, 5'b00100);
    set_vec(15, 32'h7F800000, 32'h00000000, 1'b0, 8'hFF, 129,  5'b00001);

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mul1 = 32'd0; mul2 = 32'd0;
    tick(); tick();
    @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_outputs", {8'd0, actual_out()}, 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Latency: one op, result exactly two edges after acceptance
    tick();
    out_ready = 1'b1;
    drive(0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_cycle1", {31'd0, out_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("latency_cycle2", {31'd0, out_valid}, 32'd1);
    drain("latency_drain");

    // Table streaming at full rate
    stalls = 0;
    for (int i = 0; i < NV; i++) begin
      drive(i);
      @(negedge clk);
      if (!in_ready) stalls++;
      tick();
    end
    in_valid = 1'b0;
    chk("stream_no_stall", stalls, 32'd0);
    drain("stream_drain");

    // Backpressure: out_ready low for 4 cycles with 4 pairs offered
    out_ready = 1'b0;
    accepts = 0;
    for (int c = 0; c < 4; c++) begin
      drive(accepts + 4);
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) accepts++;
    end
    chk("bp_accepts", accepts, 32'd2);
    drive(accepts + 4);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_full_pipe_ready", {31'd0, in_ready}, 32'd1);
    for (int c = 0; c < 10 && accepts < 4; c++) begin
      drive(accepts + 4);
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) accepts++;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", accepts, 32'd4);
    drain("bp_drain");

    // Reset with two ops in flight
    out_ready = 1'b0;
    drive(10);
    tick();
    drive(11);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    sb_q.delete();
    tick();
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_outputs", {8'd0, actual_out()}, 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    out_count = 0;
    @(negedge clk);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    for (int c = 0; c < 6; c++) tick();
    chk("midrst_no_stale", out_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
